// File: rtl/piso_serializer.sv
// Parallel-in, serial-out converter with a one-word holding buffer so that
// back-to-back words stream out with no idle bit-times between frames.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic             r_serial_out;
    logic             r_serial_valid;
    logic             r_frame_start;
    logic             r_frame_end;
    logic             r_busy;

    state_t           w_nxt_state;
    logic [CW-1:0]    w_nxt_cnt;
    logic [WIDTH-1:0] w_nxt_sreg;
    logic [WIDTH-1:0] w_nxt_hold;
    logic             w_nxt_hold_full;
    logic             w_accept;
    logic             w_in_ready;

    function automatic logic pick_bit(input logic [WIDTH-1:0] word,
                                      input logic [CW-1:0]    idx);
        if (LSB_FIRST)
            return word[idx];
        else
            return word[LAST - idx];
    endfunction

    // in_ready is the only output with a combinational term (reset).
    assign w_in_ready = !r_hold_full && !reset;
    assign w_accept   = in_valid && w_in_ready;

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_cnt       = r_cnt;
        w_nxt_sreg      = r_sreg;
        w_nxt_hold      = r_hold;
        w_nxt_hold_full = r_hold_full;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nxt_sreg  = parallel_in;
                    w_nxt_cnt   = '0;
                    w_nxt_state = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == LAST) begin
                    // Frame boundary: drain hold first, else bypass a fresh word.
                    w_nxt_cnt = '0;
                    if (r_hold_full) begin
                        w_nxt_sreg      = r_hold;
                        w_nxt_hold_full = 1'b0;
                    end else if (w_accept) begin
                        w_nxt_sreg = parallel_in;
                    end else begin
                        w_nxt_state = IDLE;
                    end
                end else begin
                    w_nxt_cnt = r_cnt + CW'(1);
                    if (w_accept) begin
                        w_nxt_hold      = parallel_in;
                        w_nxt_hold_full = 1'b1;
                    end
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they always
    // describe the bit currently on the line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_sreg         <= '0;
            r_hold         <= '0;
            r_hold_full    <= 1'b0;
            r_serial_out   <= 1'b0;
            r_serial_valid <= 1'b0;
            r_frame_start  <= 1'b0;
            r_frame_end    <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_nxt_state;
            r_cnt          <= w_nxt_cnt;
            r_sreg         <= w_nxt_sreg;
            r_hold         <= w_nxt_hold;
            r_hold_full    <= w_nxt_hold_full;
            r_serial_valid <= (w_nxt_state == SHIFT);
            r_serial_out   <= (w_nxt_state == SHIFT) ? pick_bit(w_nxt_sreg, w_nxt_cnt) : 1'b0;
            r_frame_start  <= (w_nxt_state == SHIFT) && (w_nxt_cnt == '0);
            r_frame_end    <= (w_nxt_state == SHIFT) && (w_nxt_cnt == LAST);
            r_busy         <= (w_nxt_state == SHIFT) || w_nxt_hold_full;
        end
    end

    assign in_ready     = w_in_ready;
    assign serial_out   = r_serial_out;
    assign serial_valid = r_serial_valid;
    assign frame_start  = r_frame_start;
    assign frame_end    = r_frame_end;
    assign busy         = r_busy;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: a 4-bit LSB-first and an 8-bit MSB-first instance
// checked every cycle against a bit-queue reference model.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] pin4;
    logic       in_valid4;
    logic       in_ready4, serial_out4, serial_valid4, frame_start4, frame_end4, busy4;
    logic [7:0] pin8;
    logic       in_valid8;
    logic       in_ready8, serial_out8, serial_valid8, frame_start8, frame_end8, busy8;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: the queue holds every bit still to appear on the line; its head is
    // the bit currently shown.
    bit q4[$];
    bit q8[$];
    logic acc4, acc8;
    logic [63:0] col4, col8;
    int ncol4, ncol8;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut4 (
        .clk(clk), .reset(reset), .parallel_in(pin4), .in_valid(in_valid4),
        .in_ready(in_ready4), .serial_out(serial_out4), .serial_valid(serial_valid4),
        .frame_start(frame_start4), .frame_end(frame_end4), .busy(busy4)
    );

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut8 (
        .clk(clk), .reset(reset), .parallel_in(pin8), .in_valid(in_valid8),
        .in_ready(in_ready8), .serial_out(serial_out8), .serial_valid(serial_valid8),
        .frame_start(frame_start8), .frame_end(frame_end8), .busy(busy8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string t, input int w, input int sz, input logic head,
                             input logic so, input logic sv, input logic fs,
                             input logic fe, input logic by);
        logic ev;
        ev = (sz != 0);
        chk({t, ".serial_valid"}, sv, ev);
        chk({t, ".serial_out"},   so, ev ? head : 1'b0);
        chk({t, ".frame_start"},  fs, ev && (sz % w == 0));
        chk({t, ".frame_end"},    fe, ev && (sz % w == 1));
        chk({t, ".busy"},         by, ev);
    endtask

    task automatic set_reset(input logic v);
        reset = v;
        if (v) begin
            q4.delete();
            q8.delete();
        end
        #1;
    endtask

    task automatic step();
        logic r4, r8, h4, h8;
        logic [3:0] w4;
        logic [7:0] w8;
        r4 = !reset && (q4.size() <= 4);
        r8 = !reset && (q8.size() <= 8);
        chk("d4.in_ready", in_ready4, r4);
        chk("d8.in_ready", in_ready8, r8);
        acc4 = in_valid4 && r4;
        acc8 = in_valid8 && r8;
        w4 = pin4;
        w8 = pin8;
        @(posedge clk);
        if (reset) begin
            q4.delete();
            q8.delete();
        end else begin
            if (q4.size() != 0) void'(q4.pop_front());
            if (q8.size() != 0) void'(q8.pop_front());
            if (acc4) for (int i = 0; i < 4; i++) q4.push_back(w4[i]);
            if (acc8) for (int i = 0; i < 8; i++) q8.push_back(w8[7-i]);
        end
        #1;
        h4 = (q4.size() != 0) ? q4[0] : 1'b0;
        h8 = (q8.size() != 0) ? q8[0] : 1'b0;
        check_dut("d4", 4, q4.size(), h4, serial_out4, serial_valid4, frame_start4, frame_end4, busy4);
        check_dut("d8", 8, q8.size(), h8, serial_out8, serial_valid8, frame_start8, frame_end8, busy8);
        if (serial_valid4) begin col4 = {col4[62:0], serial_out4}; ncol4++; end
        if (serial_valid8) begin col8 = {col8[62:0], serial_out8}; ncol8++; end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct {
        logic [3:0] word;
        logic [3:0] seq;   // emission order, seq[3] first
    } vec_t;

    vec_t tbl[8];
    logic [3:0] words[4];
    logic [7:0] exp8;

    initial begin
        reset = 1'b1; in_valid4 = 1'b0; in_valid8 = 1'b0; pin4 = '0; pin8 = '0;
        col4 = '0; col8 = '0; ncol4 = 0; ncol8 = 0;

        // Reset state
        step(); step();
        chk("rst.serial_valid", serial_valid4, 1'b0);
        chk("rst.serial_out",   serial_out4,   1'b0);
        chk("rst.busy",         busy8,         1'b0);
        chk("rst.in_ready",     in_ready4,     1'b0);
        set_reset(1'b0);
        chk("rst.in_ready_after", in_ready4, 1'b1);

        // Table of single words, LSB first
        tbl[0] = '{4'b1011, 4'b1101};
        tbl[1] = '{4'b0001, 4'b1000};
        tbl[2] = '{4'b1001, 4'b1001};
        tbl[3] = '{4'b0101, 4'b1010};
        tbl[4] = '{4'b0110, 4'b0110};
        tbl[5] = '{4'b1111, 4'b1111};
        tbl[6] = '{4'b0000, 4'b0000};
        tbl[7] = '{4'b1100, 4'b0011};
        for (int i = 0; i < 8; i++) begin
            in_valid4 = 1'b1; pin4 = tbl[i].word;
            step();
            in_valid4 = 1'b0; pin4 = ~tbl[i].word;
            for (int k = 0; k < 4; k++) begin
                chk("tbl.bit",         serial_out4,  tbl[i].seq[3-k]);
                chk("tbl.frame_start", frame_start4, k == 0);
                chk("tbl.frame_end",   frame_end4,   k == 3);
                if (k < 3) step();
            end
            step();
            chk("tbl.idle_valid", serial_valid4, 1'b0);
            chk("tbl.idle_busy",  busy4,         1'b0);
        end

        // 8-bit MSB first
        exp8 = 8'b1010_0101;
        in_valid8 = 1'b1; pin8 = 8'hA5;
        step();
        in_valid8 = 1'b0; pin8 = 8'h00;
        for (int k = 0; k < 8; k++) begin
            chk("w8.bit",       serial_out8, exp8[7-k]);
            chk("w8.frame_end", frame_end8,  k == 7);
            if (k < 7) step();
        end
        step();
        chk("w8.idle_valid", serial_valid8, 1'b0);

        // Back-to-back stream with continuously valid upstream
        begin
            int idx, first, endc;
            words[0] = 4'b0001; words[1] = 4'b1001; words[2] = 4'b0101; words[3] = 4'b0110;
            idx = 0; first = -1; endc = -1; ncol4 = 0; col4 = '0;
            in_valid4 = 1'b1; pin4 = words[0];
            for (int cyc = 0; cyc < 40 && ncol4 < 16; cyc++) begin
                step();
                if (acc4) begin
                    idx++;
                    if (idx < 4) pin4 = words[idx];
                    else in_valid4 = 1'b0;
                end
                if (first < 0 && serial_valid4) first = cyc;
                if (ncol4 == 16) endc = cyc;
            end
            in_valid4 = 1'b0;
            chk("b2b.bits", col4[15:0], 16'b1000_1001_1010_0110);
            chk("b2b.span", endc - first, 15);
            drain(6);
        end

        // Backpressure: second word to hold, third waits for the drain
        begin
            int wcnt;
            logic rdy;
            ncol4 = 0; col4 = '0;
            in_valid4 = 1'b1; pin4 = 4'b0011;
            step();
            pin4 = 4'b1100;
            step();
            pin4 = 4'b0101;
            wcnt = 0;
            for (int g = 0; g < 12; g++) begin
                rdy = in_ready4;
                step();
                wcnt++;
                if (rdy) break;
            end
            in_valid4 = 1'b0;
            chk("bp.wait", wcnt, 4);
            drain(12);
            chk("bp.count", ncol4, 12);
            chk("bp.bits", col4[11:0], 12'b1100_0011_1010);
        end

        // Reset mid-frame
        in_valid4 = 1'b1; pin4 = 4'b1111;
        step();
        in_valid4 = 1'b0;
        step();
        set_reset(1'b1);
        chk("mid.serial_valid", serial_valid4, 1'b0);
        chk("mid.busy",         busy4,         1'b0);
        chk("mid.in_ready",     in_ready4,     1'b0);
        step(); step();
        set_reset(1'b0);
        chk("mid.in_ready_after", in_ready4, 1'b1);
        ncol4 = 0; col4 = '0;
        in_valid4 = 1'b1; pin4 = 4'b0101;
        step();
        in_valid4 = 1'b0;
        drain(5);
        chk("mid.count", ncol4, 4);
        chk("mid.bits",  col4[3:0], 4'b1010);

        // Random traffic with occasional async reset
        for (int c = 0; c < 400; c++) begin
            in_valid4 = ($urandom_range(0, 3) != 0);
            in_valid8 = ($urandom_range(0, 3) != 0);
            pin4 = 4'($urandom);
            pin8 = 8'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                set_reset(1'b1);
                step();
                set_reset(1'b0);
            end else begin
                step();
            end
        end
        in_valid4 = 1'b0; in_valid8 = 1'b0;
        drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
